masked_serial_adder_ctrl: RTL and testbench

Bit-serial controller that sequences a 2-share masked half-adder datapath to add two Boolean-masked WIDTH-bit operands. It issues one bit position per cycle and chains two masked half-adder gadgets into a full-adder stage. Carry shares are held in registers between bit positions. The controller requests fresh refresh randomness for every stage and stalls when none is available. It sits between the operand source and the masked-arithmetic consumer, and is PROLEAD-evaluable: all outputs are registered.

---
 rtl/masked_adder_pkg.sv | 37 +++
 rtl/masked_full_adder_stage.sv | 31 +++
 rtl/masked_serial_adder_ctrl.sv | 130 +++++++++++++
 tb/tb_masked_serial_adder_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/masked_adder_pkg.sv
// Shared types and helpers for the 2-share masked bit-serial adder.
// Holds the controller state enum, default width and the masked half-adder gadget.
`timescale 1ns/1ps
package masked_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic s0;
    logic s1;
    logic c0;
    logic c1;
  } ha_out_t;

  function automatic int idx_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  // ISW-style gadget: sum is share-wise XOR, carry is a refreshed masked AND.
  function automatic ha_out_t masked_ha(input logic x0, input logic x1,
                                        input logic y0, input logic y1,
                                        input logic r);
    ha_out_t o;
    o.s0 = x0 ^ y0;
    o.s1 = x1 ^ y1;
    o.c0 = (x0 & y0) ^ r;
    o.c1 = (x1 & y1) ^ ((r ^ (x0 & y1)) ^ (x1 & y0));
    return o;
  endfunction

endpackage

// File: rtl/masked_full_adder_stage.sv
// Combinational masked full-adder stage: two chained half-adder gadgets
// with a share-wise carry merge (the two carries are never both 1).
`timescale 1ns/1ps
module masked_full_adder_stage
  import masked_adder_pkg::*;
(
  input  logic       a0,
  input  logic       a1,
  input  logic       b0,
  input  logic       b1,
  input  logic       cin0,
  input  logic       cin1,
  input  logic [1:0] r,
  output logic       s0,
  output logic       s1,
  output logic       cout0,
  output logic       cout1
);

  ha_out_t w_ha1;
  ha_out_t w_ha2;

  assign w_ha1 = masked_ha(a0, a1, b0, b1, r[0]);
  assign w_ha2 = masked_ha(w_ha1.s0, w_ha1.s1, cin0, cin1, r[1]);

  assign s0    = w_ha2.s0;
  assign s1    = w_ha2.s1;
  assign cout0 = w_ha1.c0 ^ w_ha2.c0;
  assign cout1 = w_ha1.c1 ^ w_ha2.c1;

endmodule

// File: rtl/masked_serial_adder_ctrl.sv
// Bit-serial controller for a 2-share masked adder: one bit per cycle with
// fresh randomness, stalling while none is available. All outputs registered.
`timescale 1ns/1ps
module masked_serial_adder_ctrl
  import masked_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_A0,
  input  logic [WIDTH-1:0] i_A1,
  input  logic [WIDTH-1:0] i_B0,
  input  logic [WIDTH-1:0] i_B1,
  input  logic [1:0]       i_rnd,
  input  logic             i_rnd_valid,
  output logic             o_rnd_req,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_S0,
  output logic [WIDTH-1:0] o_S1,
  output logic             o_Cout0,
  output logic             o_Cout1
);

  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_e           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a0, r_a1, r_b0, r_b1;
  logic [WIDTH-1:0] r_sum0, r_sum1;
  logic             r_c0, r_c1;

  logic             w_s0, w_s1, w_cout0, w_cout1;
  logic [WIDTH-1:0] w_sum0_next, w_sum1_next;

  masked_full_adder_stage u_stage (
    .a0    (r_a0[0]),
    .a1    (r_a1[0]),
    .b0    (r_b0[0]),
    .b1    (r_b1[0]),
    .cin0  (r_c0),
    .cin1  (r_c1),
    .r     (i_rnd),
    .s0    (w_s0),
    .s1    (w_s1),
    .cout0 (w_cout0),
    .cout1 (w_cout1)
  );

  // Sum bits enter at the MSB so bit k lands at position k after WIDTH shifts.
  assign w_sum0_next = (r_sum0 >> 1) | (WIDTH'(w_s0) << (WIDTH - 1));
  assign w_sum1_next = (r_sum1 >> 1) | (WIDTH'(w_s1) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_a0      <= '0;
      r_a1      <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_sum0    <= '0;
      r_sum1    <= '0;
      r_c0      <= 1'b0;
      r_c1      <= 1'b0;
      o_rnd_req <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_S0      <= '0;
      o_S1      <= '0;
      o_Cout0   <= 1'b0;
      o_Cout1   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a0      <= i_A0;
            r_a1      <= i_A1;
            r_b0      <= i_B0;
            r_b1      <= i_B1;
            r_c0      <= 1'b0;
            r_c1      <= 1'b0;
            r_idx     <= '0;
            r_state   <= ST_RUN;
            o_busy    <= 1'b1;
            o_rnd_req <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_rnd_valid) begin
            r_a0   <= r_a0 >> 1;
            r_a1   <= r_a1 >> 1;
            r_b0   <= r_b0 >> 1;
            r_b1   <= r_b1 >> 1;
            r_c0   <= w_cout0;
            r_c1   <= w_cout1;
            r_sum0 <= w_sum0_next;
            r_sum1 <= w_sum1_next;
            r_idx  <= r_idx + IW'(1);
            if (r_idx == LAST_IDX) begin
              r_state   <= ST_DONE;
              o_rnd_req <= 1'b0;
              o_done    <= 1'b1;
              o_S0      <= w_sum0_next;
              o_S1      <= w_sum1_next;
              o_Cout0   <= w_cout0;
              o_Cout1   <= w_cout1;
            end
          end
        end
        ST_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          o_done    <= 1'b0;
          o_busy    <= 1'b0;
          o_rnd_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_masked_serial_adder_ctrl.sv
// Scoreboard bench for masked_serial_adder_ctrl: directed additions, stall,
// start-while-busy, mid-run reset and a WIDTH=1 instance.
`timescale 1ns/1ps
module tb_masked_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    int           done_cyc;
    int           req_n;
    int           cons_n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic [W-1:0] i_A0 = '0, i_A1 = '0, i_B0 = '0, i_B1 = '0;
  logic [1:0]   i_rnd = 2'b00;
  logic         i_rnd_valid = 1'b1;
  logic         o_rnd_req, o_busy, o_done, o_Cout0, o_Cout1;
  logic [W-1:0] o_S0, o_S1;

  logic         w1_start = 1'b0;
  logic [0:0]   w1_A0 = '0, w1_A1 = '0, w1_B0 = '0, w1_B1 = '0;
  logic         w1_rnd_req, w1_busy, w1_done, w1_Cout0, w1_Cout1;
  logic [0:0]   w1_S0, w1_S1;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  masked_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_A0(i_A0), .i_A1(i_A1), .i_B0(i_B0), .i_B1(i_B1),
    .i_rnd(i_rnd), .i_rnd_valid(i_rnd_valid),
    .o_rnd_req(o_rnd_req), .o_busy(o_busy), .o_done(o_done),
    .o_S0(o_S0), .o_S1(o_S1), .o_Cout0(o_Cout0), .o_Cout1(o_Cout1)
  );

  masked_serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .i_start(w1_start),
    .i_A0(w1_A0), .i_A1(w1_A1), .i_B0(w1_B0), .i_B1(w1_B1),
    .i_rnd(i_rnd), .i_rnd_valid(1'b1),
    .o_rnd_req(w1_rnd_req), .o_busy(w1_busy), .o_done(w1_done),
    .o_S0(w1_S0), .o_S1(w1_S1), .o_Cout0(w1_Cout0), .o_Cout1(w1_Cout1)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Fresh randomness every cycle; the expected sums never depend on it.
  initial forever begin
    @(posedge clk);
    #1 i_rnd = 2'($urandom_range(0, 3));
  end

  // Monitor: tally randomness use and compare every o_done against the scoreboard.
  initial begin : monitor
    int req_n;
    int cons_n;
    exp_t e;
    req_n = 0;
    cons_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_n = 0;
        cons_n = 0;
      end else begin
        if (o_rnd_req) req_n++;
        if (o_rnd_req && i_rnd_valid) cons_n++;
        if (o_done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("sum", o_S0 ^ o_S1, e.s);
            chk("cout", o_Cout0 ^ o_Cout1, e.cout);
            chk("done_cycle", cyc, e.done_cyc);
            chk("rnd_req_cycles", req_n, e.req_n);
            chk("rnd_consumed", cons_n, e.cons_n);
            chk("busy_in_done", o_busy, 1);
          end
          req_n = 0;
          cons_n = 0;
        end
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input int stall, input bit poke,
                       input logic [W-1:0] es, input logic ec);
    exp_t e;
    int   t;
    @(posedge clk);
    #1;
    i_A0 = a ^ ma; i_A1 = ma;
    i_B0 = b ^ mb; i_B1 = mb;
    i_start = 1'b1;
    t = cyc;
    e.s = es; e.cout = ec; e.done_cyc = t + W + 1 + stall;
    e.req_n = W + stall; e.cons_n = W;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_A0 = ~i_A0; i_B1 = ~i_B1;
    if (stall > 0) begin
      repeat (4) @(posedge clk);
      #1 i_rnd_valid = 1'b0;
      repeat (stall) @(posedge clk);
      #1 i_rnd_valid = 1'b1;
    end
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
    end
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain", sb_q.size(), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin : driver
    logic [W-1:0] va[4], vb[4], vs[4];
    logic         vc[4];
    logic [W-1:0] s0_first, s1_first;
    int           t;
    va = '{8'h5A, 8'hFF, 8'hFF, 8'h00};
    vb = '{8'h3C, 8'h01, 8'hFF, 8'h00};
    vs = '{8'h96, 8'h00, 8'hFE, 8'h00};
    vc = '{1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_req", o_rnd_req, 0);
    chk("rst_s", {o_S0, o_S1, o_Cout0, o_Cout1}, 0);
    #1 rst = 1'b0;

    // Two share splits per operand pair; bit 0 of the masks differs, so S0 must differ.
    for (int k = 0; k < 4; k++) begin
      do_op(va[k], vb[k], 8'hA7, 8'h12, 0, 1'b0, vs[k], vc[k]);
      s0_first = o_S0;
      s1_first = o_S1;
      do_op(va[k], vb[k], 8'h6E, 8'hC4, 0, 1'b0, vs[k], vc[k]);
      chk("s0_share_varies", (o_S0 != s0_first), 1);
      chk("s1_share_varies", (o_S1 != s1_first), 1);
    end

    do_op(8'h5A, 8'h3C, 8'h33, 8'h9D, 3, 1'b0, 8'h96, 1'b0);
    do_op(8'h5A, 8'h3C, 8'h0F, 8'hF0, 0, 1'b1, 8'h96, 1'b0);
    chk("hold_after_poke", o_S0 ^ o_S1, 8'h96);

    // Reset in cycle t+5 of a run.
    @(posedge clk);
    #1;
    i_A0 = 8'h12; i_A1 = 8'h34; i_B0 = 8'h56; i_B1 = 8'h78;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    chk("midrst_req", o_rnd_req, 0);
    chk("midrst_out", {o_S0, o_S1, o_Cout0, o_Cout1}, 0);
    do_op(8'hC3, 8'h5A, 8'h81, 8'h7E, 0, 1'b0, 8'h1D, 1'b1);

    // WIDTH=1: 1 + 1 gives S=0, Cout=1 with o_done at t+2.
    @(posedge clk);
    #1;
    w1_A0 = 1'b0; w1_A1 = 1'b1; w1_B0 = 1'b1; w1_B1 = 1'b0;
    w1_start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 w1_start = 1'b0;
    @(negedge clk);
    chk("w1_busy_t1", w1_busy, 1);
    chk("w1_done_t1", w1_done, 0);
    @(posedge clk);
    @(negedge clk);
    chk("w1_done_cycle", cyc - t, 2);
    chk("w1_done", w1_done, 1);
    chk("w1_sum", w1_S0 ^ w1_S1, 0);
    chk("w1_cout", w1_Cout0 ^ w1_Cout1, 1);
    @(negedge clk);
    chk("w1_done_pulse", w1_done, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
